// File: rtl/ovi_load_emitter.sv
// ovi_load_emitter
//
// OVI-side transmitter for the VPU load-data path. It takes one unit-stride load
// request at a time and packs the 64-bit words returned by the core LSU into 512-bit
// OVI load lines. Each line is tagged with a sequence id, and the load ends with a
// memop sync_end pulse.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_*               load request handshake and attributes (sb_id, vd, sew, vl)
//   word_*              LSU return word handshake; elements packed little-endian from bit 0
//   kill                abort the load in flight
//   load_*              registered OVI load beat (data, seq_id, valid); mask tied off
//   memop_*             registered end-of-load pulse and the sb_id it belongs to
//
// Timing: the load_* and memop_* registers are loaded from the state that owns them,
// EMIT or SYNC. The beat and the sync pulse are therefore visible in the cycle after
// that state. kill and rst, when sampled during that state, stop the pulse.

module ovi_load_emitter #(
    parameter int unsigned MEMDATA_W = 512,
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned SBID_W    = 5,
    parameter int unsigned VL_W      = 15
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SBID_W-1:0]    req_sb_id,
    input  logic [4:0]           req_vd,
    input  logic [1:0]           req_sew,
    input  logic [VL_W-1:0]      req_vl,

    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic [WORD_W-1:0]    word_data,

    input  logic                 kill,

    output logic                 load_valid,
    output logic [MEMDATA_W-1:0] load_data,
    output logic [33:0]          load_seq_id,
    output logic [63:0]          load_mask,
    output logic                 load_mask_valid,

    output logic                 memop_sync_end,
    output logic [SBID_W-1:0]    memop_sb_id,
    output logic [14:0]          memop_vstart_vlfof
);

    // Number of LSU words in one OVI line. This is 8 for the 512/64 configuration.
    localparam int unsigned NumWords = MEMDATA_W / WORD_W;
    localparam int unsigned WIdxW    = $clog2(NumWords);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StEmit,
        StSync
    } state_e;

    state_e               state_q;
    logic [SBID_W-1:0]    sb_id_q;
    logic [4:0]           vd_q;
    logic [1:0]           sew_q;
    logic [VL_W-1:0]      vl_q;
    logic [10:0]          el_id_q;   // first element of the line being filled
    logic [4:0]           beat_q;    // beat index; v_reg = vd + beat wraps mod 32
    logic [WIdxW:0]       wcnt_q;    // words accepted into the current line
    logic [MEMDATA_W-1:0] line_q;

    // Per-line derived quantities
    logic [VL_W-1:0] el_id_w;
    logic [VL_W-1:0] rem;
    logic [VL_W-1:0] el_next;
    logic [6:0]      epl;       // elements per line
    logic [3:0]      epw;       // elements per word
    logic [6:0]      n_el;      // elements carried by this line
    logic [7:0]      wsum;
    logic [WIdxW:0]  wneed;     // words needed to cover n_el elements
    logic [WIdxW:0]  wcnt_inc;
    logic [4:0]      v_reg;

    always_comb begin
        el_id_w  = VL_W'(el_id_q);
        rem      = vl_q - el_id_w;
        epl      = 7'd64 >> sew_q;
        epw      = 4'd8 >> sew_q;
        // rem is below epl (at most 64) in the first branch, so rem fits in 7 bits.
        n_el     = (rem < VL_W'(epl)) ? rem[6:0] : epl;
        // ceil(n_el / epw); epw is a power of two: 2^(3-sew)
        wsum     = 8'(n_el) + 8'(epw) - 8'd1;
        wneed    = (WIdxW + 1)'(wsum >> (2'd3 - sew_q));
        el_next  = el_id_w + VL_W'(n_el);
        wcnt_inc = wcnt_q + 1'b1;
        v_reg    = vd_q + beat_q;
    end

    // The handshakes depend only on state, so the LSU can always hold a word stable
    // until it is taken.
    assign req_ready  = (state_q == StIdle);
    assign word_ready = (state_q == StFill);

    assign load_mask          = '0;
    assign load_mask_valid    = 1'b0;
    assign memop_vstart_vlfof = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            sb_id_q        <= '0;
            vd_q           <= '0;
            sew_q          <= '0;
            vl_q           <= '0;
            el_id_q        <= '0;
            beat_q         <= '0;
            wcnt_q         <= '0;
            line_q         <= '0;
            load_valid     <= 1'b0;
            load_data      <= '0;
            load_seq_id    <= '0;
            memop_sync_end <= 1'b0;
            memop_sb_id    <= '0;
        end else begin
            // These two are single-cycle pulses.
            load_valid     <= 1'b0;
            memop_sync_end <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    // kill has no effect here; a request in the same cycle still wins.
                    if (req_valid) begin
                        sb_id_q <= req_sb_id;
                        vd_q    <= req_vd;
                        sew_q   <= req_sew;
                        vl_q    <= req_vl;
                        el_id_q <= '0;
                        beat_q  <= '0;
                        wcnt_q  <= '0;
                        line_q  <= '0;
                        state_q <= (req_vl == '0) ? StSync : StFill;
                    end
                end

                StFill: begin
                    if (kill) begin
                        line_q  <= '0;
                        wcnt_q  <= '0;
                        state_q <= StIdle;
                    end else if (word_valid) begin
                        line_q[{wcnt_q[WIdxW-1:0], 6'b0} +: WORD_W] <= word_data;
                        wcnt_q <= wcnt_inc;
                        if (wcnt_inc == wneed) begin
                            state_q <= StEmit;
                        end
                    end
                end

                StEmit: begin
                    if (kill) begin
                        // Sampled ahead of the output register, so the beat never leaves.
                        line_q  <= '0;
                        wcnt_q  <= '0;
                        state_q <= StIdle;
                    end else begin
                        load_valid  <= 1'b1;
                        load_data   <= line_q;
                        load_seq_id <= {sb_id_q, n_el, 6'd0, el_id_q, v_reg};
                        el_id_q     <= el_next[10:0];
                        beat_q      <= beat_q + 5'd1;
                        wcnt_q      <= '0;
                        line_q      <= '0;
                        state_q     <= (el_next == vl_q) ? StSync : StFill;
                    end
                end

                StSync: begin
                    state_q <= StIdle;
                    if (!kill) begin
                        memop_sync_end <= 1'b1;
                        memop_sb_id    <= sb_id_q;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
